// File: rtl/rv_alu_pkg.sv
// Execute-stage ALU/MDU types: MDU operation encoding (RV funct3), MDU FSM
// states and operand signedness helpers.
package rv_alu_pkg;

    localparam int unsigned MDU_OP_W = 3;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    // rs1 is interpreted as signed by these operations
    function automatic logic mdu_signed_a(input logic [MDU_OP_W-1:0] op);
        return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    endfunction

    // rs2 is interpreted as signed by these operations
    function automatic logic mdu_signed_b(input logic [MDU_OP_W-1:0] op);
        return op inside {MDU_MULH, MDU_DIV, MDU_REM};
    endfunction

endpackage

// File: rtl/rv_pkg.sv
// Core-wide constants shared by the execute-stage units.
//   XLEN : architectural register width.
package rv_pkg;

    localparam int unsigned XLEN = 32;

endpackage

// File: rtl/rv_mdu_core.sv
// Shared iterative datapath of the MDU: one 2*XLEN accumulator used either as
// {remainder, dividend/quotient} for restoring division or as
// {product-high, multiplier/product-low} for shift-add multiplication, plus the
// iteration counter. No handshake logic lives here.
// Macro: RV_MDU_FAST_MUL_EN removes the shift-add multiply step.
// Ports:
//   clk_i, rstn_i   clock, synchronous active-low reset
//   start_i         load operands and preset counter to XLEN-1
//   step_i          perform one iteration and decrement the counter
//   div_i           operation class at start (1 = divide, 0 = multiply)
//   op_a_i, op_b_i  operand magnitudes
//   last_c          counter is zero (current step is the final one)
//   acc_next_c      accumulator value after the current step
module rv_mdu_core #(
    parameter int unsigned XLEN = rv_pkg::XLEN
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                start_i,
    input  logic                step_i,
    input  logic                div_i,
    input  logic [XLEN-1:0]     op_a_i,
    input  logic [XLEN-1:0]     op_b_i,
    output logic                last_c,
    output logic [2*XLEN-1:0]   acc_next_c
);

    localparam int unsigned ACC_W = 2 * XLEN;
    localparam int unsigned CNT_W = $clog2(XLEN);

    logic [ACC_W-1:0] acc_q;
    logic [XLEN-1:0]  opd_q;
    logic             div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN:0]    trial;
`ifndef RV_MDU_FAST_MUL_EN
    logic [XLEN:0]    sum;
`endif

    // One iteration: trial-subtract of the shifted partial remainder, or
    // conditional add of the multiplicand followed by a right shift.
    always_comb begin
        acc_next_c = acc_q;
        trial      = acc_q[ACC_W-1:XLEN-1] - {1'b0, opd_q};
`ifndef RV_MDU_FAST_MUL_EN
        sum        = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
`endif
        if (div_q) begin
            if (!trial[XLEN]) begin
                acc_next_c = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_next_c = {acc_q[ACC_W-2:0], 1'b0};
            end
        end
`ifndef RV_MDU_FAST_MUL_EN
        else begin
            acc_next_c = {sum, acc_q[XLEN-1:1]};
        end
`endif
    end

    assign last_c = (cnt_q == '0);

    // Accumulator, operand and counter registers
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            acc_q <= '0;
            opd_q <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else if (start_i) begin
            acc_q <= div_i ? {XLEN'(0), op_a_i} : {XLEN'(0), op_b_i};
            opd_q <= div_i ? op_b_i : op_a_i;
            div_q <= div_i;
            cnt_q <= CNT_W'(XLEN - 1);
        end else if (step_i) begin
            acc_q <= acc_next_c;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/rv_mdu.sv
// RV32M multiply/divide unit: request/response valid-ready handshakes,
// IDLE/CALC/DONE control, operand sign handling, special-case divide results
// and result sign correction around the iterative rv_mdu_core datapath.
// Macro: RV_MDU_FAST_MUL_EN selects a single-cycle combinational multiply.
// Ports:
//   clk_i, rstn_i        clock, synchronous active-low reset
//   mdu_req_i            request valid
//   mdu_ready_o          unit idle and able to accept
//   mdu_op_i             operation (RV funct3)
//   mdu_port_a_i/_b_i    rs1 / rs2 operands
//   mdu_kill_i           abort the operation in flight
//   mdu_res_valid_o      result valid
//   mdu_res_ready_i      consumer accepts result
//   mdu_result_o         result, held while valid
module rv_mdu
    import rv_alu_pkg::*;
#(
    parameter int unsigned XLEN = rv_pkg::XLEN
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                mdu_req_i,
    output logic                mdu_ready_o,
    input  logic [MDU_OP_W-1:0] mdu_op_i,
    input  logic [XLEN-1:0]     mdu_port_a_i,
    input  logic [XLEN-1:0]     mdu_port_b_i,
    input  logic                mdu_kill_i,
    output logic                mdu_res_valid_o,
    input  logic                mdu_res_ready_i,
    output logic [XLEN-1:0]     mdu_result_o
);

    localparam int unsigned ACC_W = 2 * XLEN;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_CALC = CALC;
    localparam logic [1:0] S_DONE = DONE;

    localparam logic [XLEN-1:0] ONES    = '1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]          state_q, state_d;
    logic [MDU_OP_W-1:0] op_q;
    logic                neg_q;

    logic                accept, is_div, is_rem, a_neg, b_neg, res_neg;
    logic                div_zero, div_ovf, special, direct, load;
    logic [XLEN-1:0]     a_mag, b_mag, special_res, res_d, calc_res, div_sel;
    logic [ACC_W-1:0]    core_acc, prod;
    logic                core_start, core_step, core_last;
`ifdef RV_MDU_FAST_MUL_EN
    logic [ACC_W-1:0]    fast_prod;
    logic [XLEN-1:0]     fast_res;
`endif

    // Request decode: magnitudes, result sign and early-exit divide cases
    always_comb begin
        accept      = mdu_req_i & mdu_ready_o & ~mdu_kill_i;
        is_div      = mdu_op_i[2];
        is_rem      = mdu_op_i[2] & mdu_op_i[1];
        a_neg       = mdu_signed_a(mdu_op_i) & mdu_port_a_i[XLEN-1];
        b_neg       = mdu_signed_b(mdu_op_i) & mdu_port_b_i[XLEN-1];
        a_mag       = a_neg ? -mdu_port_a_i : mdu_port_a_i;
        b_mag       = b_neg ? -mdu_port_b_i : mdu_port_b_i;
        res_neg     = is_rem ? a_neg : (a_neg ^ b_neg);
        div_zero    = is_div & (mdu_port_b_i == '0);
        div_ovf     = is_div & ~mdu_op_i[0] & (mdu_port_a_i == INT_MIN) & (mdu_port_b_i == ONES);
        special     = div_zero | div_ovf;
        if (div_zero) begin
            special_res = is_rem ? mdu_port_a_i : ONES;
        end else begin
            special_res = is_rem ? '0 : mdu_port_a_i;
        end
`ifdef RV_MDU_FAST_MUL_EN
        // Sign-extended operands; the low 2*XLEN bits of the product are exact
        fast_prod   = {{XLEN{a_neg}}, mdu_port_a_i} * {{XLEN{b_neg}}, mdu_port_b_i};
        fast_res    = (mdu_op_i == MDU_MUL) ? fast_prod[XLEN-1:0] : fast_prod[ACC_W-1:XLEN];
        direct      = special | ~is_div;
`else
        direct      = special;
`endif
    end

    // Final result from the accumulator value written by the last iteration
    always_comb begin
        prod     = neg_q ? -core_acc : core_acc;
        div_sel  = op_q[1] ? core_acc[ACC_W-1:XLEN] : core_acc[XLEN-1:0];
        if (op_q[2]) begin
            calc_res = neg_q ? -div_sel : div_sel;
        end else begin
            calc_res = (op_q == MDU_MUL) ? prod[XLEN-1:0] : prod[ACC_W-1:XLEN];
        end
    end

    assign core_start = accept & ~direct;
    assign core_step  = (state_q == S_CALC) & ~mdu_kill_i;

    rv_mdu_core #(
        .XLEN       (XLEN)
    ) u_core (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .start_i    (core_start),
        .step_i     (core_step),
        .div_i      (is_div),
        .op_a_i     (a_mag),
        .op_b_i     (b_mag),
        .last_c     (core_last),
        .acc_next_c (core_acc)
    );

    // Next-state and result-load logic
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        res_d   = calc_res;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (direct) begin
                        state_d = S_DONE;
                        load    = 1'b1;
`ifdef RV_MDU_FAST_MUL_EN
                        res_d   = special ? special_res : fast_res;
`else
                        res_d   = special_res;
`endif
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (mdu_kill_i) begin
                    state_d = S_IDLE;
                end else if (core_last) begin
                    state_d = S_DONE;
                    load    = 1'b1;
                end
            end
            S_DONE: begin
                if (mdu_kill_i || mdu_res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, registered handshake outputs and latched request attributes
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q         <= S_IDLE;
            mdu_ready_o     <= 1'b1;
            mdu_res_valid_o <= 1'b0;
            mdu_result_o    <= '0;
            op_q            <= '0;
            neg_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            mdu_ready_o     <= (state_d == S_IDLE);
            mdu_res_valid_o <= (state_d == S_DONE);
            if (load) begin
                mdu_result_o <= res_d;
            end
            if (accept) begin
                op_q  <= mdu_op_i;
                neg_q <= res_neg;
            end
        end
    end

endmodule

// File: tb/tb_rv_mdu.sv
// Scoreboard bench for rv_mdu: directed RV32M corner cases, backpressure,
// kill/reset aborts and randomized operations against a 64-bit arithmetic model.
module tb_rv_mdu;
    import rv_alu_pkg::*;

    localparam int unsigned XLEN = 32;
`ifdef RV_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;

    logic              clk_i;
    logic              rstn_i;
    logic              mdu_req_i;
    logic              mdu_ready_o;
    logic [2:0]        mdu_op_i;
    logic [XLEN-1:0]   mdu_port_a_i;
    logic [XLEN-1:0]   mdu_port_b_i;
    logic              mdu_kill_i;
    logic              mdu_res_valid_o;
    logic              mdu_res_ready_i = 1'b1;
    logic [XLEN-1:0]   mdu_result_o;

    rv_mdu #(.XLEN(XLEN)) dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .mdu_req_i       (mdu_req_i),
        .mdu_ready_o     (mdu_ready_o),
        .mdu_op_i        (mdu_op_i),
        .mdu_port_a_i    (mdu_port_a_i),
        .mdu_port_b_i    (mdu_port_b_i),
        .mdu_kill_i      (mdu_kill_i),
        .mdu_res_valid_o (mdu_res_valid_o),
        .mdu_res_ready_i (mdu_res_ready_i),
        .mdu_result_o    (mdu_result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] res;
        int          edge_no;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } dir_t;

    exp_t scb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_n  = 0;
    int   bp_mode = 2;   // 0 random, 1 hold low, 2 hold high

    always @(posedge clk_i) edge_n <= edge_n + 1;

    always @(posedge clk_i) begin
        #1;
        case (bp_mode)
            0:       mdu_res_ready_i = ($urandom_range(0, 3) != 0);
            1:       mdu_res_ready_i = 1'b0;
            default: mdu_res_ready_i = 1'b1;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: RV32M semantics via 64-bit integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sbv, ua, ub;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'(a);
        ub  = longint'(b);
        p   = '0;
        case (op)
            MDU_MUL:    begin p = sa * sbv; return p[31:0];  end
            MDU_MULH:   begin p = sa * sbv; return p[63:32]; end
            MDU_MULHSU: begin p = sa * ub;  return p[63:32]; end
            MDU_MULHU:  begin p = ua * ub;  return p[63:32]; end
            MDU_DIV: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sbv; return p[31:0];
            end
            MDU_DIVU: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            MDU_REM: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sbv; return p[31:0];
            end
            default: begin
                if (b == 32'h0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2]) begin
            if (b == 32'h0) return 1;
            if ((op == MDU_DIV || op == MDU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return DIV_LAT;
        end
        return MUL_LAT;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic scramble();
        mdu_port_a_i = $urandom;
        mdu_port_b_i = $urandom;
        mdu_op_i     = 3'($urandom);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
            scramble();
        end
    endtask

    // Wait for ready, present one request, optionally register its expectation
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push);
        int   w;
        exp_t e;
        w = 0;
        @(negedge clk_i);
        while (!mdu_ready_o && w < 200) begin
            scramble();
            @(negedge clk_i);
            w++;
        end
        if (!mdu_ready_o) begin
            check("issue_wait_ready", 64'(mdu_ready_o), 64'd1);
            return;
        end
        mdu_req_i    = 1'b1;
        mdu_op_i     = op;
        mdu_port_a_i = a;
        mdu_port_b_i = b;
        @(posedge clk_i);
        #1;
        mdu_req_i = 1'b0;
        if (push) begin
            e.res     = ref_model(op, a, b);
            e.edge_no = edge_n + latency(op, a, b);
            scb.push_back(e);
        end
        scramble();
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (scb.size() != 0 && w < 500) begin
            @(negedge clk_i);
            w++;
        end
        check("drain_empty", 64'(scb.size()), 64'd0);
    endtask

    // Monitor: compare on first valid cycle, check hold-stability, check release
    bit          holding  = 1'b0;
    bit          post_chk = 1'b0;
    logic [31:0] held     = '0;

    always @(negedge clk_i) begin
        if (post_chk) begin
            check("idle_after_handshake", {62'd0, mdu_ready_o, mdu_res_valid_o}, 64'd2);
            post_chk = 1'b0;
        end
        if (mdu_res_valid_o) begin
            if (!holding) begin
                if (scb.size() == 0) begin
                    check("unexpected_valid", 64'(mdu_res_valid_o), 64'd0);
                end else begin
                    check("result", 64'(mdu_result_o), 64'(scb[0].res));
                    check("latency_edge", 64'(edge_n + 1), 64'(scb[0].edge_no));
                end
                holding = 1'b1;
                held    = mdu_result_o;
            end else begin
                check("result_stable", 64'(mdu_result_o), 64'(held));
            end
            if (mdu_res_ready_i) begin
                holding  = 1'b0;
                post_chk = 1'b1;
                if (scb.size() > 0) scb.delete(0);
            end
        end else begin
            holding = 1'b0;
        end
    end

    dir_t dirs[15] = '{
        '{MDU_DIV,    32'hFFFF_FFF9, 32'h0000_0002},
        '{MDU_REM,    32'hFFFF_FFF9, 32'h0000_0002},
        '{MDU_DIVU,   32'd100,       32'd7},
        '{MDU_REMU,   32'd100,       32'd7},
        '{MDU_DIVU,   32'd100,       32'd0},
        '{MDU_REM,    32'd100,       32'd0},
        '{MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF},
        '{MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF},
        '{MDU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{MDU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{MDU_MULH,   32'h8000_0000, 32'h8000_0000},
        '{MDU_DIV,    32'h0000_0000, 32'hFFFF_FFFB},
        '{MDU_REMU,   32'hFFFF_FFFF, 32'h0000_0001}
    };

    initial begin
        int w;
        rstn_i       = 1'b0;
        mdu_req_i    = 1'b0;
        mdu_kill_i   = 1'b0;
        mdu_op_i     = '0;
        mdu_port_a_i = '0;
        mdu_port_b_i = '0;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_ready",  64'(mdu_ready_o),     64'd1);
        check("reset_valid",  64'(mdu_res_valid_o), 64'd0);
        check("reset_result", 64'(mdu_result_o),    64'd0);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;

        // Directed corner cases, consumer always ready
        foreach (dirs[i]) issue(dirs[i].op, dirs[i].a, dirs[i].b, 1'b1);
        drain();

        // Backpressure: result and valid held while the consumer stalls
        bp_mode = 1;
        tick(2);
        issue(MDU_DIVU, 32'd100, 32'd7, 1'b1);
        w = 0;
        @(negedge clk_i);
        while (!mdu_res_valid_o && w < 100) begin
            @(negedge clk_i);
            w++;
        end
        check("bp_valid_seen", 64'(mdu_res_valid_o), 64'd1);
        repeat (5) begin
            check("bp_hold", {30'd0, mdu_res_valid_o, mdu_ready_o, mdu_result_o},
                  {30'd0, 1'b1, 1'b0, 32'd14});
            @(negedge clk_i);
        end
        bp_mode = 2;
        drain();

        // Kill coincident with a request in IDLE: not accepted
        @(negedge clk_i);
        mdu_req_i    = 1'b1;
        mdu_kill_i   = 1'b1;
        mdu_op_i     = MDU_DIVU;
        mdu_port_a_i = 32'd5;
        mdu_port_b_i = 32'd0;
        @(posedge clk_i);
        #1;
        mdu_req_i  = 1'b0;
        mdu_kill_i = 1'b0;
        @(negedge clk_i);
        check("kill_idle_req", {62'd0, mdu_ready_o, mdu_res_valid_o}, 64'd2);
        tick(3);

        // Kill at the tenth iteration of a division
        issue(MDU_DIV, 32'h1234_5678, 32'd3, 1'b0);
        tick(9);
        mdu_kill_i = 1'b1;
        @(posedge clk_i);
        #1;
        mdu_kill_i = 1'b0;
        @(negedge clk_i);
        check("kill_calc", {62'd0, mdu_ready_o, mdu_res_valid_o}, 64'd2);
        tick(40);

        // Reset in the middle of an iterative operation
        issue(MDU_DIVU, 32'd1000, 32'd7, 1'b0);
        tick(5);
        rstn_i = 1'b0;
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("midop_reset", {30'd0, mdu_ready_o, mdu_res_valid_o, mdu_result_o},
              {30'd0, 1'b1, 1'b0, 32'd0});
        rstn_i = 1'b1;
        tick(40);

        // Randomized operations with random consumer backpressure
        bp_mode = 0;
        repeat (80) issue(3'($urandom), rand_operand(), rand_operand(), 1'b1);
        drain();
        bp_mode = 2;
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
